// File: rtl/enemy_pkg.sv
// Shared types and constants for the enemy kill manager.
// Holds the per-enemy life state and default timing/score values.
package enemy_pkg;

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        DYING = 2'd1,
        DEAD  = 2'd2
    } enemy_state_t;

    localparam int         DYING_FRAMES_DEF = 32;
    localparam logic [3:0] ENEMY_POINTS_DEF = 4'd5;
    localparam int         CNT_W            = 6;

    // Population count of a 3-bit vector
    function automatic logic [1:0] count3(input logic [2:0] v);
        return 2'({1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]});
    endfunction

endpackage

// File: rtl/enemy_life_fsm.sv
// Life cycle of one enemy: hit latch, ALIVE/DYING/DEAD state,
// blink frame counter and the one-cycle kill pulse.
module enemy_life_fsm
    import enemy_pkg::*;
#(
    parameter int DYING_FRAMES = DYING_FRAMES_DEF
) (
    input  logic clk,
    input  logic resetN,
    input  logic game_on,
    input  logic restart,
    input  logic startOfFrame,
    input  logic hit_pixel,
    output logic kill,
    output logic dying,
    output logic dead
);

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(DYING_FRAMES - 1);

    enemy_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             hit, hit_nxt;
    logic             kill_nxt;

    // State, counter, hit flag and kill pulse registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= ALIVE;
            cnt   <= '0;
            hit   <= 1'b0;
            kill  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hit   <= hit_nxt;
            kill  <= kill_nxt;
        end
    end

    // Next state: restart beats everything, frame ticks advance life
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hit_nxt   = hit;
        kill_nxt  = 1'b0;
        if (restart) begin
            state_nxt = ALIVE;
            cnt_nxt   = '0;
            hit_nxt   = 1'b0;
        end else if (game_on) begin
            if (startOfFrame) begin
                hit_nxt = 1'b0;
                unique case (state)
                    ALIVE: begin
                        if (hit) begin
                            state_nxt = DYING;
                            cnt_nxt   = LOAD;
                        end
                    end
                    DYING: begin
                        if (cnt == '0) begin
                            state_nxt = DEAD;
                            kill_nxt  = 1'b1;
                        end else begin
                            cnt_nxt = cnt - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (state == ALIVE && hit_pixel) begin
                hit_nxt = 1'b1;
            end
        end
    end

    assign dying = (state == DYING);
    assign dead  = (state == DEAD);

endmodule

// File: rtl/enemy_kill_manager.sv
// Tracks three enemies from explosion hit to removal and
// produces kill pulses, score increments and level status.
module enemy_kill_manager
    import enemy_pkg::*;
#(
    parameter int         DYING_FRAMES = DYING_FRAMES_DEF,
    parameter logic [3:0] ENEMY_POINTS = ENEMY_POINTS_DEF
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       game_on,
    input  logic       startOfFrame,
    input  logic [2:0] enemiesDR_BUS,
    input  logic       explosionDR,
    output logic       enemy1_kill,
    output logic       enemy2_kill,
    output logic       enemy3_kill,
    output logic [2:0] enemy_dying,
    output logic [5:0] score_add,
    output logic [1:0] enemies_left,
    output logic       level_clear
);

    logic       game_prev;
    logic       restart;
    logic [2:0] kill;
    logic [2:0] dead;

    // Registered copy of game_on for level-start detection
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            game_prev <= 1'b0;
        end else begin
            game_prev <= game_on;
        end
    end

    assign restart = game_on & ~game_prev;

    for (genvar i = 0; i < 3; i++) begin : g_enemy
        enemy_life_fsm #(
            .DYING_FRAMES(DYING_FRAMES)
        ) u_life (
            .clk         (clk),
            .resetN      (resetN),
            .game_on     (game_on),
            .restart     (restart),
            .startOfFrame(startOfFrame),
            .hit_pixel   (enemiesDR_BUS[i] & explosionDR),
            .kill        (kill[i]),
            .dying       (enemy_dying[i]),
            .dead        (dead[i])
        );
    end

    assign enemy1_kill  = kill[0];
    assign enemy2_kill  = kill[1];
    assign enemy3_kill  = kill[2];
    assign score_add    = 6'(ENEMY_POINTS) * {4'b0, count3(kill)};
    assign enemies_left = 2'd3 - count3(dead);
    assign level_clear  = game_on & (&dead);

endmodule

// File: doc/enemy_kill_manager.md
ENEMY_KILL_MANAGER -- requirements
Module: enemy_kill_manager

Interface
REQ-001 Parameter DYING_FRAMES, default 32, meaning number of frames an enemy blinks between hit and removal (range 1..63).
REQ-002 Parameter ENEMY_POINTS, default 4'd5, meaning score value added per enemy killed.
REQ-003 clk  input  1  system clock; one clock; all state updates on posedge clk.
REQ-004 resetN  input  1  reset, asynchronous, active-low.
REQ-005 game_on  input  1  high while a level is being played.
REQ-006 startOfFrame  input  1  one-cycle pulse at the start of each video frame.
REQ-007 enemiesDR_BUS  input  3  one-hot per-pixel enemy draw bus from the enemies mux (bit i = enemy i+1).
REQ-008 explosionDR  input  1  explosion draw request for the current pixel.
REQ-009 enemy1_kill, enemy2_kill, enemy3_kill  output  1 each  one-cycle kill pulse to the enemies mux.
REQ-010 enemy_dying  output  3  bit i high while enemy i+1 is in DYING (drives blink).
REQ-011 score_add  output  6  points to add this cycle; zero when no kill.
REQ-012 enemies_left  output  2  count of enemies not DEAD.
REQ-013 level_clear  output  1  high while game_on and all three enemies DEAD.

Function
REQ-014 Each enemy SHALL own a state machine ALIVE -> DYING -> DEAD; no other transitions except level restart and reset.
REQ-015 While game_on and ALIVE, a cycle with enemiesDR_BUS[i] && explosionDR SHALL set a registered hit flag for enemy i; the flag stays set until the next startOfFrame.
REQ-016 On startOfFrame, an ALIVE enemy with hit flag set SHALL enter DYING with frame counter loaded to DYING_FRAMES-1; the hit flag clears on every startOfFrame.
REQ-017 In DYING, each startOfFrame SHALL decrement the counter; on startOfFrame with counter 0 the enemy SHALL enter DEAD and its killN output SHALL pulse high exactly one cycle (the cycle after that startOfFrame edge).
REQ-018 Hits on enemies in DYING or DEAD SHALL be ignored.
REQ-019 enemy_dying[i] SHALL equal (state==DYING), registered.
REQ-020 score_add SHALL equal ENEMY_POINTS times the number of kill pulses asserted in the same cycle (0..3), zero-extended to 6 bits; simultaneous kills SHALL all pulse in the same cycle.
REQ-021 enemies_left SHALL be 3 minus number of DEAD enemies, updated the cycle after the transition.
REQ-022 While game_on is low, hit detection and counters SHALL freeze; states hold.
REQ-023 On the first cycle game_on is high after being low (rising edge, detected with a registered copy of game_on), all enemies SHALL return to ALIVE, counters and hit flags clear, kills not pulsed.
REQ-024 If a level restart and a startOfFrame coincide, the restart SHALL win.

Reset
REQ-025 On resetN low, asynchronously: all states ALIVE, counters 0, hit flags 0, game_on history 0, enemy1/2/3_kill 0, enemy_dying 0, score_add 0, enemies_left 3, level_clear 0.
REQ-026 Reset asserted mid-DYING SHALL abort the sequence with no kill pulse.

Structure
REQ-027 Shared package enemy_pkg SHALL hold the state enum (ALIVE, DYING, DEAD), default DYING_FRAMES, and ENEMY_POINTS.
REQ-028 Sub-module enemy_life_fsm (one enemy: hit flag, state, counter, kill pulse) SHALL be instantiated three times; the top adds score, count, and level_clear logic.

Verification
REQ-029 Reset, game_on=1, enemiesDR_BUS=001 with explosionDR=1 one cycle -> enemy_dying=001 after next startOfFrame; enemy1_kill pulses once after 32nd subsequent startOfFrame; score_add=5 that cycle; enemies_left=2.
REQ-030 Hits on enemies 2 and 3 in the same frame -> both kill pulses same cycle, score_add=10, enemies_left=1.
REQ-031 All three killed -> level_clear=1; drop game_on then raise -> level_clear=0, enemies_left=3, no kill pulses.
REQ-032 Repeated hits on enemy 1 while DYING -> kill timing unchanged, single pulse, no extra score.
REQ-033 resetN low at DYING counter 10 -> all outputs at reset values immediately, no kill pulse after release.
REQ-034 game_on low with enemiesDR_BUS=010 and explosionDR=1 across several frames -> no state change, enemy_dying=000.
